uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL provide parameter SAMPLE_DIV, default 650, giving sysclk cycles per 16x-oversample tick (9600 baud from 100 MHz).
REQ-002 SHALL provide port sysclk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port rx  input  1  serial line, idle high, asynchronous to sysclk.
REQ-005 SHALL provide port rx_data  output  8  last correctly framed byte.
REQ-006 SHALL provide port rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-007 SHALL provide port frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-008 SHALL provide port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer with both flops reset to 1; all logic uses the synchronized value (rx_s) plus one further registered copy (rx_d) for edge detection.
REQ-010 SHALL use a tick divider counting 0..SAMPLE_DIV-1 that produces a one-cycle tick when it equals SAMPLE_DIV-1 and then wraps to 0; it is held at 0 in IDLE.
REQ-011 SHALL use a 4-bit tick index counting ticks 1..16 within each bit period, followed by a bit boundary; it is reset to 0 on entry to START.
REQ-012 SHALL use FSM states IDLE, START, DATA and STOP.
REQ-013 In IDLE, the FSM SHALL go to START on a falling edge (rx_d=1, rx_s=0).
  - A low line already low when IDLE is entered is not an edge.
  - rx must return high before re-arming.
REQ-014 In every state, the FSM SHALL capture rx_s on ticks 7, 8 and 9 of the bit and take the bit value as the 2-of-3 majority.
REQ-015 In START, at tick 9:
  - majority 0: continue and enter DATA at the bit boundary.
  - majority 1: treat as a glitch and return to IDLE with no output pulse.
REQ-016 In DATA, the FSM SHALL shift in 8 bits LSB first, each decided at tick 9, and enter STOP after the 8th bit boundary.
REQ-017 In STOP, at tick 9:
  - majority 1: load rx_data with the shift register and pulse rx_valid.
  - majority 0: pulse frame_err and leave rx_data unchanged.
  - In both cases, return to IDLE in the same cycle without waiting for the end of the stop bit.
REQ-018 Latency: rx_valid/frame_err SHALL assert in the cycle after the 153rd tick following the START entry cycle, i.e. 153*SAMPLE_DIV cycles after START entry.
REQ-019 rx_valid and frame_err SHALL never assert in the same cycle and SHALL each last exactly one cycle.
REQ-020 busy SHALL be 1 from the START entry cycle through the cycle in which the FSM returns to IDLE.
REQ-021 The divider SHALL be at least 10 bits wide so that SAMPLE_DIV values up to 1023 are supported.
REQ-022 SAMPLE_DIV values below 2 SHALL be treated as unsupported.

Reset
REQ-023 Asserting reset SHALL immediately force:
  - state IDLE, divider and tick index 0, shift register 0;
  - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0;
  - both synchronizer flops and rx_d to 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no pulse; reception SHALL restart only on the next falling edge after reset deasserts.

Verification (SAMPLE_DIV=4, bit period = 64 cycles)
REQ-025 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_valid single pulse 612 cycles after START entry, rx_data=8'hA5, frame_err never 1.
REQ-026 Frame 0x3C with stop bit 0 -> frame_err single pulse at 612 cycles, rx_valid stays 0, rx_data keeps its previous value; line then held low -> busy stays 0 until rx rises and falls again.
REQ-027 Low glitch of 8 cycles on idle line -> busy high for about 36 cycles, then IDLE; no rx_valid or frame_err.
REQ-028 Frame 0x55 with a 4-cycle high glitch at tick 8 of bit 3 -> majority vote rejects it, rx_data=8'h55.
REQ-029 Reset pulse during bit 4 of a frame -> outputs cleared immediately, no pulse; next clean frame 0x81 received correctly, rx_data=8'h81.
REQ-030 Back-to-back frames 0x01, 0xFF with no idle gap -> two rx_valid pulses 640 cycles apart with rx_data 8'h01 then 8'hFF.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting per bit.
// SAMPLE_DIV sets sysclk cycles per oversample tick; values below 2 are unsupported.
module uart_receiver #(
    parameter int SAMPLE_DIV = 650
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W = ($clog2(SAMPLE_DIV) > 10) ? $clog2(SAMPLE_DIV) : 10;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, next_state;

    logic             rx_meta, rx_s, rx_d;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tick_idx;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             samp7, samp8;
    logic             tick, at_decide, at_boundary, vote, fall_edge;
    logic             load_byte, flag_err;

    // Synchronizer plus one extra stage for falling-edge detection; all idle high.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign fall_edge   = rx_d & ~rx_s;
    assign tick        = (state != IDLE) && (div_cnt == DIV_LAST);
    assign at_decide   = tick && (tick_idx == 4'd8);
    assign at_boundary = tick && (tick_idx == 4'd15);
    assign vote        = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
    assign busy        = (state != IDLE);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bit decisions fall on tick 9; the stop bit is resolved there without waiting for its end.
    always_comb begin
        next_state = state;
        load_byte  = 1'b0;
        flag_err   = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    next_state = START;
                end
            end
            START: begin
                if (at_decide && vote) begin
                    next_state = IDLE;
                end else if (at_boundary) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (at_boundary && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (at_decide) begin
                    next_state = IDLE;
                    if (vote) begin
                        load_byte = 1'b1;
                    end else begin
                        flag_err = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Divider and tick index sit at zero in IDLE so each frame is timed from START entry.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            tick_idx <= 4'd0;
        end else if (state == IDLE) begin
            div_cnt  <= '0;
            tick_idx <= 4'd0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_idx <= tick_idx + 4'd1;
        end else begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (tick) begin
            if (tick_idx == 4'd6) begin
                samp7 <= rx_s;
            end
            if (tick_idx == 4'd7) begin
                samp8 <= rx_s;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (at_boundary) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if ((state == DATA) && at_decide) begin
                shift_reg <= {vote, shift_reg[7:1]};
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= load_byte;
            frame_err <= flag_err;
            if (load_byte) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed table-driven bench for uart_receiver with SAMPLE_DIV=4 (64 cycles per bit).
module tb_uart_receiver;

    localparam int BIT_CYC = 64;
    localparam int LAT     = 612;

    logic       sysclk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cycle = 0;
    int busy_rises = 0, start_cycle = 0, busy_len = 0;
    int valid_cnt = 0, err_cnt = 0, last_latency = 0;
    int last_vcycle = 0, prev_vcycle = 0;
    logic [7:0] last_vdata = 8'h00, prev_vdata = 8'h00;
    int overlap = 0, wide = 0;
    logic busy_q = 1'b0, valid_q = 1'b0, err_q = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(.SAMPLE_DIV(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cycle++;

    // Event recorder sampled on the falling edge, away from the active edge.
    always @(negedge sysclk) begin
        if (busy && !busy_q) begin
            busy_rises++;
            start_cycle = cycle;
        end
        if (!busy && busy_q) busy_len = cycle - start_cycle;
        if (rx_valid) begin
            valid_cnt++;
            prev_vcycle  = last_vcycle;
            prev_vdata   = last_vdata;
            last_vcycle  = cycle;
            last_vdata   = rx_data;
            last_latency = cycle - start_cycle;
        end
        if (frame_err) begin
            err_cnt++;
            last_latency = cycle - start_cycle;
        end
        if (rx_valid && frame_err) overlap++;
        if ((rx_valid && valid_q) || (frame_err && err_q)) wide++;
        busy_q  = busy;
        valid_q = rx_valid;
        err_q   = frame_err;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one 10-bit frame from a negedge; optionally inverts g_len cycles of bit g_bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int g_bit, input int g_off, input int g_len);
        logic [9:0] frame;
        logic       val;
        frame = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                val = frame[b];
                if (b == g_bit && c >= g_off && c < g_off + g_len) val = ~val;
                rx = val;
                @(negedge sysclk);
            end
        end
    endtask

    task automatic idleHigh(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sysclk);
    endtask

    int v0, e0, r0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[4] = '{8'h6E, 1'b0, 0, 1, 8'hFF};
        vecs[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge sysclk);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_frame_err", frame_err, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        reset = 1'b0;
        idleHigh(20);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[i].data, vecs[i].stop_bit, -1, 0, 0);
            idleHigh(100);
            checkOutput($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d_err_pulses", i), err_cnt - e0, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_latency", i), last_latency, LAT);
            checkOutput($sformatf("vec%0d_busy_len", i), busy_len, LAT);
        end

        // Short low glitch on idle line
        v0 = valid_cnt; e0 = err_cnt; r0 = busy_rises;
        rx = 1'b0;
        repeat (8) @(negedge sysclk);
        idleHigh(200);
        checkOutput("glitch_busy_len", busy_len, 36);
        checkOutput("glitch_busy_rises", busy_rises - r0, 1);
        checkOutput("glitch_no_valid", valid_cnt - v0, 0);
        checkOutput("glitch_no_err", err_cnt - e0, 0);

        // High glitch covering only tick 8 of data bit 3
        v0 = valid_cnt;
        applyStimulus(8'h55, 1'b1, 4, 31, 4);
        idleHigh(100);
        checkOutput("vote_valid", valid_cnt - v0, 1);
        checkOutput("vote_rx_data", rx_data, 8'h55);

        // Stop bit low, then line held low: no re-arm until rx rises and falls
        v0 = valid_cnt; e0 = err_cnt; r0 = busy_rises;
        applyStimulus(8'h3C, 1'b0, -1, 0, 0);
        repeat (300) @(negedge sysclk);
        checkOutput("low_err_pulses", err_cnt - e0, 1);
        checkOutput("low_no_valid", valid_cnt - v0, 0);
        checkOutput("low_busy_rises", busy_rises - r0, 1);
        checkOutput("low_busy", busy, 1'b0);
        checkOutput("low_rx_data_kept", rx_data, 8'h55);
        idleHigh(20);
        checkOutput("low_no_rearm", busy_rises - r0, 1);
        applyStimulus(8'h5A, 1'b1, -1, 0, 0);
        idleHigh(100);
        checkOutput("rearm_rx_data", rx_data, 8'h5A);
        checkOutput("rearm_valid", valid_cnt - v0, 1);

        // Reset during data bit 4 of a frame
        v0 = valid_cnt; e0 = err_cnt;
        rx = 1'b0;
        repeat (5 * BIT_CYC) @(negedge sysclk);
        rx = 1'b1;
        repeat (20) @(negedge sysclk);
        checkOutput("midframe_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_rx_data", rx_data, 8'h00);
        checkOutput("async_rst_busy", busy, 1'b0);
        checkOutput("async_rst_valid", rx_valid, 1'b0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        r0 = busy_rises;
        idleHigh(800);
        checkOutput("abort_no_valid", valid_cnt - v0, 0);
        checkOutput("abort_no_err", err_cnt - e0, 0);
        checkOutput("abort_no_restart", busy_rises - r0, 0);
        applyStimulus(8'h81, 1'b1, -1, 0, 0);
        idleHigh(100);
        checkOutput("after_rst_rx_data", rx_data, 8'h81);
        checkOutput("after_rst_valid", valid_cnt - v0, 1);

        // Back-to-back frames with no idle gap
        v0 = valid_cnt;
        applyStimulus(8'h01, 1'b1, -1, 0, 0);
        applyStimulus(8'hFF, 1'b1, -1, 0, 0);
        idleHigh(100);
        checkOutput("b2b_pulses", valid_cnt - v0, 2);
        checkOutput("b2b_spacing", last_vcycle - prev_vcycle, 640);
        checkOutput("b2b_first_data", prev_vdata, 8'h01);
        checkOutput("b2b_second_data", last_vdata, 8'hFF);

        checkOutput("pulse_overlap", overlap, 0);
        checkOutput("pulse_width", wide, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
